// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction store for the RISC-V fetch path. Provides a
// byte-enabled program-load write port and a ready/valid fetch port with a
// 1- or 2-cycle latency. After every reset the array is zeroed one word per
// cycle; fetches and loads are locked out until that sweep completes.
module instr_mem_ctrl #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 64,
    parameter int               ADDR_W   = 6,
    parameter int               READ_LAT = 1,
    parameter logic [WIDTH-1:0] NOP_WORD = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_stall,
    output logic                 rd_ready,
    output logic [WIDTH-1:0]     instruct,
    output logic                 rd_valid,
    output logic                 rd_err,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_be,
    output logic                 busy
);
    localparam int                NBYTES    = WIDTH / 8;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              accept;
    logic              rd_oor;
    logic              wr_oor;
    logic [WIDTH-1:0]  rd_word;

    // Values presented to the output register by the selected latency path
    logic              stage_vld;
    logic              stage_err;
    logic [WIDTH-1:0]  stage_data;

    // Merge the enabled bytes of a load word into the existing word
    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]  old_word,
                                                     input logic [WIDTH-1:0]  new_word,
                                                     input logic [NBYTES-1:0] be);
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Addresses are unsigned; widen by one bit so DEPTH itself is representable
    assign rd_oor   = ({1'b0, rd_addr} >= DEPTH_EXT);
    assign wr_oor   = ({1'b0, wr_addr} >= DEPTH_EXT);
    assign rd_ready = (state == RUN) & ~rd_stall;
    assign accept   = rd_en & rd_ready;

    // Combinational array read; out-of-range fetches never touch the array
    always_comb begin
        rd_word = NOP_WORD;
        if (!rd_oor) rd_word = mem[rd_addr];
    end

    // Clear/run sequencer: sweep every word once, then open the ports
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else if (state == CLEAR) begin
            if (clr_cnt == LAST_ADDR) begin
                state <= RUN;
                busy  <= 1'b0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Array writes: zero fill during the sweep, byte-enabled loads afterwards
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en && !wr_oor) begin
            mem[wr_addr] <= merge_bytes(mem[wr_addr], wr_data, wr_be);
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             vld_p0;
            logic             err_p0;
            logic [WIDTH-1:0] data_p0;

            // Stage p0: request valid, frozen by stall, dropped by reset
            always_ff @(posedge clk) begin
                if (rst)            vld_p0 <= 1'b0;
                else if (!rd_stall) vld_p0 <= accept;
            end

            // Stage p0: registered array read for the accepted request
            always_ff @(posedge clk) begin
                if (!rd_stall && accept) begin
                    data_p0 <= rd_word;
                    err_p0  <= rd_oor;
                end
            end

            assign stage_vld  = vld_p0;
            assign stage_err  = err_p0;
            assign stage_data = data_p0;
        end else begin : g_lat1
            assign stage_vld  = accept;
            assign stage_err  = rd_oor;
            assign stage_data = rd_word;
        end
    endgenerate

    // Output stage: new result on valid, instruct holds otherwise, all frozen on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            instruct <= NOP_WORD;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (!rd_stall) begin
            rd_valid <= stage_vld;
            rd_err   <= stage_vld & stage_err;
            if (stage_vld) instruct <= stage_data;
        end
    end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the RISC_V core, replacing the fixed 64x32 store. It adds a byte-enabled program-load write port and a fetch read port with a ready/valid handshake and configurable read latency (1 or 2). It also has a stall input, out-of-range detection that returns a NOP, and a sequential post-reset clear sequence. It sits between the PC/fetch stage and the decode stage; the loader drives the write port from the testbench or boot logic.

Parameters:
WIDTH, 32, instruction word width in bits; multiple of 8
DEPTH, 64, number of words; need not be a power of 2
ADDR_W, 6, word-address width; must satisfy 2^ADDR_W >= DEPTH
READ_LAT, 1, fetch latency in cycles; only 1 or 2 are legal
NOP_WORD, 32'h00000013, word returned on reset and on out-of-range fetch

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
rd_en  in  1  fetch request
rd_addr  in  ADDR_W  fetch word address
rd_stall  in  1  freeze fetch pipeline
rd_ready  out  1  request accepted this cycle when rd_en & rd_ready
instruct  out  WIDTH  fetched instruction, registered
rd_valid  out  1  instruct holds a new fetch result
rd_err  out  1  qualifies rd_valid; the fetch address was >= DEPTH
wr_en  in  1  load write strobe
wr_addr  in  ADDR_W  load word address
wr_data  in  WIDTH  load data
wr_be  in  WIDTH/8  byte enables for wr_data
busy  out  1  high while clear sequence runs

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), registered values after that edge:
  - instruct=NOP_WORD, rd_valid=0, rd_err=0.
  - busy=1, FSM=CLEAR, clear counter=0.
  - Internal pipeline valid bits are cleared.
- FSM states: CLEAR and RUN.
  - CLEAR: writes 0 to word[cnt] each cycle, cnt increments from 0 to DEPTH-1.
  - On the cycle that writes word DEPTH-1, the FSM moves to RUN. busy=0 from the next cycle.
  - The clear therefore takes exactly DEPTH cycles after rst deasserts.
  - In CLEAR: rd_ready=0, wr_en is ignored, rd_valid=0.
- rd_ready = (state==RUN) & ~rd_stall, combinational.
- Fetch accepted (rd_en & rd_ready at edge N):
  - READ_LAT=1: instruct and rd_valid=1 update at edge N+1.
  - READ_LAT=2: the array read registers at N+1; instruct and rd_valid=1 update at N+2.
  - One fetch per cycle; back-to-back fetches give rd_valid=1 on consecutive cycles.
- No accept in a cycle (and not stalled): rd_valid=0 at the corresponding output edge. instruct holds its last value.
- Stall (rd_stall=1):
  - Every pipeline register, instruct, rd_valid and rd_err hold their values.
  - Nothing is accepted.
  - An in-flight READ_LAT=2 fetch resumes on the first unstalled cycle.
- Out of range (rd_addr >= DEPTH): the fetch is still accepted. It returns instruct=NOP_WORD with rd_err=1 and rd_valid=1. The array is not accessed.
- Write, in RUN with wr_en=1 and wr_addr < DEPTH: byte i of word[wr_addr] is updated from wr_data[8i+7:8i] where wr_be[i]=1.
  - A write to wr_addr >= DEPTH is silently dropped.
  - Writes are independent of rd_stall.
- Same-address read and write in one cycle: read-first. The fetch returns the pre-write contents; the new data is visible to fetches accepted from the next cycle.
- Reset mid-operation: in-flight fetches are discarded (no rd_valid). The clear restarts at word 0 regardless of progress. Memory contents are zeroed again.
- Width rules:
  - rd_addr and wr_addr are compared as unsigned ADDR_W values.
  - The clear counter is ADDR_W bits wide and never exceeds DEPTH-1.

Test Plan:
- Clear: rst for 2 cycles, release. Required: busy=1 for exactly 64 cycles, rd_ready=0 throughout, rd_valid=0; then busy=0 and rd_ready=1.
- Load/fetch, READ_LAT=1: write 0xDEADBEEF to addr 5 with wr_be=4'hF. Fetch addr 5. Required: next cycle instruct=0xDEADBEEF, rd_valid=1, rd_err=0.
- Byte enable and read-first: word 5 holds 0xDEADBEEF. In the same cycle, write 0x11223344 to addr 5 with wr_be=4'b0101 and fetch addr 5. Required: the fetch returns 0xDEADBEEF; the next fetch returns 0xDE22BE44.
- Latency and stall, READ_LAT=2: fetch addrs 1, 2, 3 back-to-back, with rd_stall=1 for 2 cycles after the second accept. Required: results in order 1, 2, 3, each with rd_valid=1 exactly once. Outputs are frozen during the stall and the overall latency is +2 cycles.
- Out of range, DEPTH=48: fetch addr 50. Required: instruct=0x00000013, rd_valid=1, rd_err=1. A write to addr 50 leaves words 0..47 unchanged.
- Reset mid-operation: issue a fetch, and assert rst on the cycle before its result. Required: no rd_valid pulse, instruct=0x00000013, a full 64-cycle clear, and a previously written word reads back as 0.
